// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing and RGB test-pattern source (pattern logic under VIDEO_TIMING_GEN_PATTERN_EN)
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       pattern_sel,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             sof,
    output logic [7:0]       frame_cnt,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             x_last;
    logic             y_last;
    logic             origin;
    logic             de_next;
    logic [23:0]      pix;

    assign x_last  = (x == H_LAST);
    assign y_last  = (y == V_LAST);
    assign origin  = (x == '0) && (y == '0);
    assign de_next = (x < H_ACT) && (y < V_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= 8'd0;
        end else if (en) begin
            x <= x_last ? '0 : x + 1'b1;
            if (x_last) begin
                y <= y_last ? '0 : y + 1'b1;
                if (y_last) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // Every output is a one-cycle registered view of the same (x,y) pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
            sof   <= 1'b0;
            red   <= 8'd0;
            green <= 8'd0;
            blue  <= 8'd0;
        end else if (en) begin
            h_cnt <= x;
            v_cnt <= y;
            hsync <= ((x >= HS_START) && (x < HS_END)) ? HS_POL : ~HS_POL;
            vsync <= ((y >= VS_START) && (y < VS_END)) ? VS_POL : ~VS_POL;
            de    <= de_next;
            sof   <= origin;
            red   <= de_next ? pix[23:16] : 8'd0;
            green <= de_next ? pix[15:8]  : 8'd0;
            blue  <= de_next ? pix[7:0]   : 8'd0;
        end else begin
            sof <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    logic [1:0]       pat_q;
    logic [1:0]       pat_cur;
    logic [CNT_W-1:0] bar_cnt;
    logic [2:0]       bar_idx;

    // The origin pixel already uses the newly sampled selection so the whole frame is consistent.
    assign pat_cur = origin ? pattern_sel : pat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= 2'd0;
            bar_cnt <= '0;
            bar_idx <= 3'd0;
        end else if (en) begin
            if (origin) begin
                pat_q <= pattern_sel;
            end
            if (x_last) begin
                bar_cnt <= '0;
                bar_idx <= 3'd0;
            end else if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

    // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to R=~b1, G=~b2, B=~b0.
    always_comb begin
        pix = 24'd0;
        case (pat_cur)
            2'd0:    pix = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd1:    pix = {3{x[7:0]}};
            2'd2:    pix = {24{x[5] ^ y[5]}};
            default: pix = {24{(x[4:0] == 5'd0) || (y[4:0] == 5'd0)}};
        endcase
    end
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = ^pattern_sel;
    assign pix = 24'd0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a reduced 24x8 raster
module tb_video_timing_gen;

    localparam int HA = 16, HF = 2, HSW = 4, HB = 2;
    localparam int VA = 4,  VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        sof;
        logic [7:0]  fc;
        logic [23:0] rgb;
    } exp_t;

    localparam exp_t RST_EXP = '{h: 12'd0, v: 12'd0, hs: 1'b0, vs: 1'b0, de: 1'b0,
                                 sof: 1'b0, fc: 8'd0, rgb: 24'd0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [11:0] h_cnt, v_cnt, h_cnt2, v_cnt2;
    logic        hsync, vsync, de, sof, hsync2, vsync2, de2, sof2;
    logic [7:0]  frame_cnt, red, green, blue, frame_cnt2, red2, green2, blue2;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .hsync(hsync), .vsync(vsync), .de(de), .sof(sof),
        .frame_cnt(frame_cnt), .red(red), .green(green), .blue(blue)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
    ) dut_neg (
        .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
        .h_cnt(h_cnt2), .v_cnt(v_cnt2), .hsync(hsync2), .vsync(vsync2), .de(de2), .sof(sof2),
        .frame_cnt(frame_cnt2), .red(red2), .green(green2), .blue(blue2)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] ref_pix(input int px, input int py, input logic [1:0] p);
        logic [31:0] ux, uy;
        ux = px;
        uy = py;
        if (px >= HA || py >= VA) return 24'd0;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        case (p)
            2'd0:    return bar_colour(px / (HA / 8));
            2'd1:    return {3{ux[7:0]}};
            2'd2:    return (ux[5] ^ uy[5]) ? 24'hFFFFFF : 24'd0;
            default: return (ux[4:0] == 0 || uy[4:0] == 0) ? 24'hFFFFFF : 24'd0;
        endcase
`else
        return (p == 2'd0 && ux == 32'hFFFF_FFFF) ? 24'd1 : 24'd0;
`endif
    endfunction

    // Reference raster: pushes the expected output for each clock edge.
    int         mx, my;
    logic [7:0] mf;
    logic [1:0] mpat;
    exp_t       prev;

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        logic [1:0] p;
        logic wrap;
        if (!rst_n) begin
            mx   <= 0;
            my   <= 0;
            mf   <= 8'd0;
            mpat <= 2'd0;
            prev <= RST_EXP;
        end else if (!en) begin
            e = prev;
            e.sof = 1'b0;
            exp_q.push_back(e);
            prev <= e;
        end else begin
            p    = (mx == 0 && my == 0) ? pattern_sel : mpat;
            wrap = (mx == HT - 1) && (my == VT - 1);
            e.h   = 12'(mx);
            e.v   = 12'(my);
            e.de  = (mx < HA) && (my < VA);
            e.hs  = (mx >= HA + HF) && (mx < HA + HF + HSW);
            e.vs  = (my >= VA + VF) && (my < VA + VF + VSW);
            e.sof = (mx == 0) && (my == 0);
            e.fc  = wrap ? mf + 8'd1 : mf;
            e.rgb = ref_pix(mx, my, p);
            exp_q.push_back(e);
            prev <= e;
            if (mx == 0 && my == 0) mpat <= pattern_sel;
            mx <= (mx == HT - 1) ? 0 : mx + 1;
            if (mx == HT - 1) my <= (my == VT - 1) ? 0 : my + 1;
            if (wrap) mf <= mf + 8'd1;
        end
    end

    exp_t got1, got2;
    assign got1 = '{h: h_cnt, v: v_cnt, hs: hsync, vs: vsync, de: de, sof: sof,
                    fc: frame_cnt, rgb: {red, green, blue}};
    assign got2 = '{h: h_cnt2, v: v_cnt2, hs: ~hsync2, vs: ~vsync2, de: de2, sof: sof2,
                    fc: frame_cnt2, rgb: {red2, green2, blue2}};

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            chk("reset_state", 64'(got1), 64'(RST_EXP));
            chk("reset_state_negpol", 64'(got2), 64'(RST_EXP));
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("raster", 64'(got1), 64'(e));
            chk("raster_negpol", 64'(got2), 64'(e));
        end
    end

    task automatic wait_px(input int px, input int py);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (h_cnt == 12'(px) && v_cnt == 12'(py)) return;
        end
        chk("wait_px_timeout", 64'(h_cnt), 64'(px));
    endtask

    task automatic next_px;
        @(posedge clk);
        @(negedge clk);
    endtask

    int cnt;

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        pattern_sel = 2'd0;
        repeat (4) @(negedge clk);
        chk("reset_hsync", 64'(hsync), 64'd0);
        chk("reset_hsync_negpol", 64'(hsync2), 64'd1);

        @(posedge clk);
        #2 rst_n = 1'b1;
        next_px();
        chk("first_pixel", 64'({h_cnt, v_cnt, de, sof}), 64'({12'd0, 12'd0, 1'b1, 1'b1}));

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        wait_px(1, 0);  chk("bar0_last",  64'({red, green, blue}), 64'h00FFFFFF);
        wait_px(2, 0);  chk("bar1_first", 64'({red, green, blue}), 64'h00FFFF00);
        wait_px(13, 0); chk("bar6_last",  64'({red, green, blue}), 64'h000000FF);
        wait_px(14, 0); chk("bar7_first", 64'({red, green, blue}), 64'h00000000);
`else
        wait_px(1, 0);  chk("rgb_off_bar0", 64'({red, green, blue}), 64'h0);
        wait_px(2, 0);  chk("rgb_off_bar1", 64'({red, green, blue}), 64'h0);
`endif
        wait_px(15, 0); chk("de_last_active", 64'(de), 64'd1);
        next_px();      chk("de_fall", 64'({de, red, green, blue}), 64'h0);
        wait_px(17, 0); chk("hs_before", 64'({hsync, hsync2}), 64'b01);
        next_px();      chk("hs_start", 64'({hsync, hsync2}), 64'b10);
        wait_px(21, 0); chk("hs_end", 64'({hsync, hsync2}), 64'b10);
        next_px();      chk("hs_after", 64'({hsync, hsync2}), 64'b01);
        wait_px(23, 0);
        next_px();      chk("h_wrap", 64'({h_cnt, v_cnt}), 64'({12'd0, 12'd1}));
        wait_px(23, 4); chk("vs_before", 64'({vsync, vsync2}), 64'b01);
        next_px();      chk("vs_start", 64'({vsync, vsync2}), 64'b10);
        wait_px(23, 6); chk("vs_end", 64'({vsync, vsync2}), 64'b10);
        next_px();      chk("vs_after", 64'({vsync, vsync2}), 64'b01);
        wait_px(23, 7); chk("fc_last_pixel", 64'(frame_cnt), 64'd1);
        next_px();      chk("v_wrap_sof", 64'({h_cnt, v_cnt, sof}), 64'({12'd0, 12'd0, 1'b1}));

        // Mid-frame pattern change is deferred to the next frame.
        wait_px(0, 2);
        pattern_sel = 2'd1;
        wait_px(5, 2);
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        chk("pattern_held", 64'({red, green, blue}), 64'h0000FFFF);
        wait_px(5, 0);
        chk("gradient_px5", 64'({red, green, blue}), 64'h00050505);
`else
        chk("pattern_off", 64'({red, green, blue}), 64'h0);
        wait_px(5, 0);
`endif

        wait_px(7, 1);
        @(posedge clk);
        #2 en = 1'b0;
        repeat (10) @(negedge clk);
        chk("freeze_pos", 64'({h_cnt, v_cnt, sof}), 64'({12'd8, 12'd1, 1'b0}));
        en = 1'b1;
        next_px();
        chk("resume_pos", 64'({h_cnt, v_cnt}), 64'({12'd9, 12'd1}));

        pattern_sel = 2'd3;
        wait_px(23, 7);
        @(posedge clk);
        #2 en = 1'b0;
        next_px();
        chk("freeze_sof", 64'({h_cnt, v_cnt, de, sof}), 64'({12'd0, 12'd0, 1'b1, 1'b0}));
        en = 1'b1;
        next_px();
        chk("resume_after_sof", 64'(h_cnt), 64'd1);
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        wait_px(0, 1); chk("hatch_x0", 64'({red, green, blue}), 64'h00FFFFFF);
        next_px();     chk("hatch_x1", 64'({red, green, blue}), 64'h0);
`endif
        pattern_sel = 2'd2;

        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!sof && cnt < 1000);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!sof && cnt < 1000);
        chk("sof_period", 64'(cnt), 64'(HT * VT));

        cnt = 0;
        while (frame_cnt != 8'd255 && cnt < 60000) begin @(negedge clk); cnt++; end
        chk("fc_reach_255", 64'(frame_cnt), 64'd255);
        cnt = 0;
        while (frame_cnt != 8'd0 && cnt < 1000) begin @(negedge clk); cnt++; end
        chk("fc_wrap", 64'({frame_cnt, h_cnt, v_cnt}), 64'({8'd0, 12'd23, 12'd7}));

        wait_px(10, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'({h_cnt, v_cnt, de, frame_cnt}), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
